// File: rtl/fifo_uart_pkg.sv
// fifo_uart_pkg: shared types and constants for the FIFO-to-UART transmit path.
//   tx_state_t : transmitter FSM state encoding
//   PAR_*      : parity mode selectors for fifo_uart_tx.PARITY
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter for one serial bit period.
//   clk      in  clock, rising edge
//   rst_n    in  synchronous active-low reset
//   clear    in  restart the bit period (asserted on every FSM state change)
//   bit_tick out high on the last cycle of each CLKS_PER_BIT-cycle period
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned      CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (bit_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a synchronous FIFO and sends each as a UART
// frame (start, DATA_WIDTH bits LSB first, optional parity, one stop bit).
//   clk          in  clock, rising edge
//   rst_n        in  synchronous active-low reset
//   enable       in  allows a new fetch; only looked at in IDLE
//   fifo_empty   in  FIFO empty flag
//   fifo_rd_data in  FIFO registered read data (valid the cycle after r_en)
//   fifo_r_en    out one-cycle read pulse per word
//   tx           out registered serial line, idle high
//   busy         out high whenever the FSM is not in IDLE
//   tx_done      out one-cycle pulse in the first IDLE cycle after a stop bit
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned      BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    tx_state_t             state, state_next;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  par_q, par_d;
    logic                  tx_d;
    logic                  bit_tick;
    logic                  timer_clear;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (timer_clear),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_next = state;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        par_d      = par_q;
        fifo_r_en  = 1'b0;
        busy       = (state != ST_IDLE);

        case (state)
            ST_IDLE: begin
                if (enable && !fifo_empty) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                fifo_r_en  = 1'b1;
                state_next = ST_LOAD;
            end
            ST_LOAD: begin
                shift_d    = fifo_rd_data;
                par_d      = (PARITY == PAR_ODD) ? ~(^fifo_rd_data) : ^fifo_rd_data;
                bit_cnt_d  = '0;
                state_next = ST_START;
            end
            ST_START: begin
                if (bit_tick) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_tick) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_tick) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // tx is registered, so its next level follows the next state; this
        // lines the line level up exactly with the state it belongs to.
        case (state_next)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase

        // Restart the bit period on every transition so each state begins at count 0.
        timer_clear = (state_next != state);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tx        <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_q     <= par_d;
            tx        <= tx_d;
            tx_done   <= (state == ST_STOP) && bit_tick;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: three transmitters (PARITY 0, 1, 2; DATA_WIDTH 8,
// CLKS_PER_BIT 4), each fed by its own behavioral 8-deep synchronous FIFO.
// Frames are captured cycle by cycle and compared with hand-written bit strings.
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst_n;
    logic en       [3];
    logic tx_w     [3];
    logic r_en_w   [3];
    logic busy_w   [3];
    logic done_w   [3];
    logic empty_w  [3];

    logic [7:0] mem [3][8];
    int         wr  [3];
    int         rcnt[3];
    int         dcnt[3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : ch
        int         rd   = 0;
        logic [7:0] dout = '0;

        always @(posedge clk) begin
            if (r_en_w[g] && (wr[g] != rd)) begin
                dout <= mem[g][rd % 8];
                rd   <= rd + 1;
            end
        end

        assign empty_w[g] = (wr[g] == rd);

        fifo_uart_tx #(
            .DATA_WIDTH   (8),
            .CLKS_PER_BIT (4),
            .PARITY       (g)
        ) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .enable       (en[g]),
            .fifo_empty   (empty_w[g]),
            .fifo_rd_data (dout),
            .fifo_r_en    (r_en_w[g]),
            .tx           (tx_w[g]),
            .busy         (busy_w[g]),
            .tx_done      (done_w[g])
        );
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (r_en_w[g]) rcnt[g] = rcnt[g] + 1;
            if (done_w[g]) dcnt[g] = dcnt[g] + 1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    typedef struct {
        int         inst;
        logic [7:0] data;
        int         nbits;
        logic [15:0] bits;   // line levels in send order, first bit at [nbits-1]
    } vec_t;

    vec_t tbl[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input int g, input logic [7:0] d);
        mem[g][wr[g] % 8] = d;
        wr[g] = wr[g] + 1;
    endtask

    function automatic logic [63:0] expand(input logic [15:0] bits, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = n - 1; i >= 0; i--) r = {r[59:0], {4{bits[i]}}};
        return r;
    endfunction

    // Counts idle-high cycles until tx falls, then records one sample per cycle
    // of the whole frame; returns on the last stop-bit cycle.
    task automatic capture(input int g, input int nbits, output logic [63:0] cyc,
                           output int waited);
        cyc    = '0;
        waited = 0;
        @(negedge clk);
        while (tx_w[g] !== 1'b0 && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (tx_w[g] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL start_timeout: actual=no_start required=start_bit inst=%0d", g);
            return;
        end
        for (int i = 0; i < nbits * 4; i++) begin
            if (i > 0) @(negedge clk);
            cyc = {cyc[62:0], tx_w[g]};
        end
    endtask

    logic [63:0] cyc;
    int          waited;
    int          r0, d0;

    initial begin
        tbl[0] = '{inst: 0, data: 8'hA5, nbits: 10, bits: 16'b0101001011};
        tbl[1] = '{inst: 1, data: 8'h07, nbits: 11, bits: 16'b01110000011};
        tbl[2] = '{inst: 2, data: 8'h07, nbits: 11, bits: 16'b01110000001};

        for (int g = 0; g < 3; g++) begin
            en[g] = 1'b1;
            wr[g] = 0;
        end
        rst_n = 1'b0;

        // Reset with enable high and all FIFOs empty
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx",      64'(tx_w[0]),   64'h1);
        check("reset_r_en",    64'(r_en_w[0]), 64'h0);
        check("reset_busy",    64'(busy_w[0]), 64'h0);
        check("reset_tx_done", 64'(done_w[0]), 64'h0);
        rst_n = 1'b1;
        r0 = rcnt[0];
        repeat (10) @(negedge clk);
        check("idle_no_fetch", 64'(rcnt[0] - r0), 64'h0);
        check("idle_busy",     64'(busy_w[0]),    64'h0);

        // Table: single frames, including even/odd parity
        for (int i = 0; i < 3; i++) begin
            r0 = rcnt[tbl[i].inst];
            d0 = dcnt[tbl[i].inst];
            push(tbl[i].inst, tbl[i].data);
            capture(tbl[i].inst, tbl[i].nbits, cyc, waited);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_frame", i), cyc, expand(tbl[i].bits, tbl[i].nbits));
            check($sformatf("vec%0d_latency", i), 64'(waited), 64'd2);
            check($sformatf("vec%0d_r_en_pulses", i), 64'(rcnt[tbl[i].inst] - r0), 64'd1);
            check($sformatf("vec%0d_tx_done", i), 64'(dcnt[tbl[i].inst] - d0), 64'd1);
            check($sformatf("vec%0d_fifo_empty", i), 64'(empty_w[tbl[i].inst]), 64'h1);
            check($sformatf("vec%0d_busy", i), 64'(busy_w[tbl[i].inst]), 64'h0);
        end

        // Back-to-back: three words queued, 3 idle-high cycles between frames
        r0 = rcnt[0];
        d0 = dcnt[0];
        push(0, 8'h01);
        push(0, 8'h02);
        push(0, 8'h03);
        capture(0, 10, cyc, waited);
        check("b2b0_frame", cyc, expand(16'b0100000001, 10));
        check("b2b0_latency", 64'(waited), 64'd2);
        capture(0, 10, cyc, waited);
        check("b2b1_frame", cyc, expand(16'b0010000001, 10));
        check("b2b1_gap", 64'(waited), 64'd3);
        capture(0, 10, cyc, waited);
        check("b2b2_frame", cyc, expand(16'b0110000001, 10));
        check("b2b2_gap", 64'(waited), 64'd3);
        repeat (2) @(negedge clk);
        check("b2b_r_en_pulses", 64'(rcnt[0] - r0), 64'd3);
        check("b2b_tx_done",     64'(dcnt[0] - d0), 64'd3);

        // Enable dropped during the data bits of the first word
        r0 = rcnt[0];
        push(0, 8'h11);
        push(0, 8'h22);
        fork
            capture(0, 10, cyc, waited);
            begin
                repeat (10) @(negedge clk);
                en[0] = 1'b0;
            end
        join
        check("endrop_frame", cyc, expand(16'b0100010001, 10));
        repeat (20) @(negedge clk);
        check("endrop_no_fetch", 64'(rcnt[0] - r0), 64'd1);
        check("endrop_pending",  64'(empty_w[0]),    64'h0);
        check("endrop_busy",     64'(busy_w[0]),     64'h0);
        en[0] = 1'b1;
        capture(0, 10, cyc, waited);
        check("endrop_resume_frame", cyc, expand(16'b0010001001, 10));
        check("endrop_resume_latency", 64'(waited), 64'd2);
        repeat (2) @(negedge clk);
        check("endrop_r_en_pulses", 64'(rcnt[0] - r0), 64'd2);

        // Reset during the start bit of 0x55; 0x3C is sent afterwards
        r0 = rcnt[0];
        push(0, 8'h55);
        push(0, 8'h3C);
        waited = 0;
        @(negedge clk);
        while (tx_w[0] !== 1'b0 && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        check("rst_mid_start_seen", 64'(tx_w[0]), 64'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_tx",   64'(tx_w[0]),   64'h1);
        check("rst_mid_busy", 64'(busy_w[0]), 64'h0);
        rst_n = 1'b1;
        capture(0, 10, cyc, waited);
        check("rst_mid_next_frame", cyc, expand(16'b0001111001, 10));
        check("rst_mid_latency", 64'(waited), 64'd2);
        repeat (2) @(negedge clk);
        check("rst_mid_r_en_pulses", 64'(rcnt[0] - r0), 64'd2);
        check("rst_mid_fifo_empty",  64'(empty_w[0]),   64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
